// File: rtl/noc_sched_pkg.sv
// noc_sched_pkg: shared constants and types for the output port scheduler
package noc_sched_pkg;
    localparam int WIDTH_DEF = 33;
    localparam int NUM_SRC = 4;
    typedef logic [1:0] src_id_t;
    localparam src_id_t SRC_A = 2'd0;
    localparam src_id_t SRC_B = 2'd1;
    localparam src_id_t SRC_C = 2'd2;
    localparam src_id_t SRC_D = 2'd3;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker over four requests
module rr_pick4
    import noc_sched_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  src_id_t            ptr,
    output logic               any,
    output src_id_t            winner
);
    // descending scan so the lowest offset from ptr wins
    always_comb begin
        any = |req;
        winner = ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (req[ptr + src_id_t'(k)]) winner = ptr + src_id_t'(k);
    end
endmodule

// File: rtl/output_port_scheduler.sv
// output_port_scheduler: round-robin, credit-gated arbiter for one router output
module output_port_scheduler
    import noc_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_SRC*WIDTH-1:0]     in_data,
    input  logic [NUM_SRC-1:0]           in_valid,
    output logic [NUM_SRC-1:0]           in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         credit_in,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic [1:0]                   grant_id,
    output logic                         credit_err
);
    localparam int CW = $clog2(CREDITS + 1);
    src_id_t ptr;
    src_id_t winner;
    logic any;
    logic load;
    rr_pick4 u_pick (
        .req(in_valid),
        .ptr(ptr),
        .any(any),
        .winner(winner)
    );
    // a flit loads when the output slot frees up this cycle and a credit is held
    always_comb begin
        load = (!out_valid || out_ready) && (credit_cnt != '0) && any;
        in_ready = (reset_n && load) ? (4'b0001 << winner) : '0;
    end
    // output register, pointer and credit bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            out_valid <= 1'b0;
            grant_id <= '0;
            ptr <= '0;
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            if (load) begin
                out_data <= in_data[winner*WIDTH +: WIDTH];
                grant_id <= winner;
                out_valid <= 1'b1;
                ptr <= winner + 2'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            credit_cnt <= (credit_in && !load) ? ((credit_cnt == CW'(CREDITS)) ? credit_cnt : credit_cnt + CW'(1))
                        : (load && !credit_in) ? credit_cnt - CW'(1) : credit_cnt;
            if (credit_in && !load && credit_cnt == CW'(CREDITS)) credit_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_output_port_scheduler.sv
// tb_output_port_scheduler: model-checked directed bench for the output port scheduler
module tb_output_port_scheduler;
    localparam int W = 33;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [4*W-1:0] in_data;
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic [W-1:0] out_data;
    logic out_valid;
    logic out_ready = 1'b0;
    logic credit_in = 1'b0;
    logic [2:0] credit_cnt;
    logic [1:0] grant_id;
    logic credit_err;
    int vectors = 0;
    int miscompares = 0;

    logic m_ov;
    logic [W-1:0] m_od;
    int m_gid, m_ptr, m_cc;
    logic m_err;

    always #5 clk = ~clk;

    output_port_scheduler #(.WIDTH(W), .CREDITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .credit_in(credit_in), .credit_cnt(credit_cnt),
        .grant_id(grant_id), .credit_err(credit_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which source may hand over a flit right now, from the rules in plain terms
    function automatic logic [3:0] exp_ready();
        if (!reset_n) return 4'b0;
        if (m_ov && !out_ready) return 4'b0;
        if (m_cc == 0) return 4'b0;
        for (int k = 0; k < 4; k++)
            if (in_valid[(m_ptr + k) % 4]) return 4'b0001 << ((m_ptr + k) % 4);
        return 4'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic [3:0] r;
        int w;
        if (!reset_n) begin
            m_ov <= 1'b0; m_od <= '0; m_gid <= 0; m_ptr <= 0; m_cc <= 4; m_err <= 1'b0;
        end else begin
            r = exp_ready();
            w = -1;
            for (int k = 0; k < 4; k++) if (r[k]) w = k;
            if (w >= 0) begin
                m_od <= in_data[w*W +: W]; m_gid <= w; m_ov <= 1'b1; m_ptr <= (w + 1) % 4;
            end else if (out_ready) m_ov <= 1'b0;
            m_cc <= (m_cc - (w >= 0 ? 1 : 0) + (credit_in ? 1 : 0) > 4) ? 4 : m_cc - (w >= 0 ? 1 : 0) + (credit_in ? 1 : 0);
            if (credit_in && w < 0 && m_cc == 4) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("grant_id", grant_id, m_gid);
        chk("credit_cnt", credit_cnt, m_cc);
        chk("credit_err", credit_err, m_err);
    end

    function automatic logic [W-1:0] flit(input int tag, input int i);
        return {1'b1, 16'h0, 8'(tag), 4'hA, 4'(i)};
    endfunction

    task automatic set_data(input int tag);
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = flit(tag, i);
    endtask

    task automatic cyc(input logic [3:0] v, input logic ordy, input logic ci, input int tag);
        in_valid = v; out_ready = ordy; credit_in = ci; set_data(tag);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 4'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_credit", credit_cnt, 3'd4);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int rr[6];
        int bd[3];
        rr = '{0, 1, 2, 3, 0, 1};
        bd = '{1, 3, 1};
        in_valid = 4'hF; out_ready = 1'b1; set_data(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ready", in_ready, 4'b0);
        chk("rst_hold_cnt", credit_cnt, 3'd4);
        reset_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cyc(4'hF, 1'b1, 1'b1, 0);
            chk("rr_gid", grant_id, 64'(rr[j]));
            chk("rr_data", out_data, flit(0, rr[j]));
            chk("rr_valid", out_valid, 1'b1);
        end
        chk("rr_first_data", out_data, 33'h1_0000_00A1);
        chk("rr_cnt", credit_cnt, 3'd4);
        do_reset();
        for (int j = 0; j < 3; j++) begin
            chk("bd_ac_ready", in_ready & 4'b0101, 4'b0);
            cyc(4'b1010, 1'b1, 1'b1, 2);
            chk("bd_gid", grant_id, 64'(bd[j]));
        end
        do_reset();
        cyc(4'hF, 1'b1, 1'b0, 3);
        chk("post_rst_gid", grant_id, 2'd0);
        repeat (3) cyc(4'hF, 1'b1, 1'b0, 3);
        chk("cr_zero", credit_cnt, 3'd0);
        chk("cr_no_ready", in_ready, 4'b0);
        cyc(4'hF, 1'b1, 1'b0, 3);
        chk("cr_drained", out_valid, 1'b0);
        cyc(4'hF, 1'b1, 1'b1, 3);
        chk("cr_one", credit_cnt, 3'd1);
        chk("cr_ready_after", in_ready, 4'b0001);
        cyc(4'hF, 1'b1, 1'b0, 3);
        chk("cr_load_gid", grant_id, 2'd0);
        chk("cr_load_cnt", credit_cnt, 3'd0);
        do_reset();
        cyc(4'hF, 1'b0, 1'b0, 5);
        for (int j = 0; j < 5; j++) begin
            cyc(4'hF, 1'b0, 1'b0, 6 + j);
            chk("stall_data", out_data, flit(5, 0));
            chk("stall_gid", grant_id, 2'd0);
            chk("stall_ready", in_ready, 4'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_ready", in_ready, 4'b0010);
        cyc(4'hF, 1'b1, 1'b0, 7);
        chk("reload_gid", grant_id, 2'd1);
        chk("reload_cnt", credit_cnt, 3'd2);
        do_reset();
        cyc(4'h0, 1'b1, 1'b1, 8);
        chk("err_set", credit_err, 1'b1);
        chk("err_cnt", credit_cnt, 3'd4);
        cyc(4'h1, 1'b1, 1'b1, 8);
        chk("coinc_cnt", credit_cnt, 3'd4);
        repeat (3) cyc(4'h0, 1'b1, 1'b0, 8);
        chk("err_sticky", credit_err, 1'b1);
        do_reset();
        for (int j = 0; j < 120; j++)
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), j);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
